// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/next-PC controller for the 5-stage pipeline: load-use interlock,
// ID-stage redirects, data-memory wait with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_uses_rt_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_stall_o,
  output logic              memwb_bubble_o,
  output logic [1:0]        pc_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              timeout_o
);

  // The wait counter only ever needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALT
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic               timeout_q, timeout_d;

  logic loadUse;
  logic idleOut, freezeOut, idRules;

  assign loadUse = idex_memread_i && (idex_rd_i != '0) &&
                   ((idex_rd_i == ifid_rs_i) ||
                    (ifid_uses_rt_i && (idex_rd_i == ifid_rt_i)));

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    idleOut   = 1'b0;
    freezeOut = 1'b0;
    idRules   = 1'b0;

    unique case (state_q)
      IDLE: begin
        idleOut = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (!start_i) begin
          idleOut = 1'b1;
          state_d = IDLE;
        end else if (mem_req_i && !mem_ack_i) begin
          freezeOut = 1'b1;
          state_d   = MEM_WAIT;
          waitCnt_d = WAIT_ONE;
        end else begin
          idRules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // start_i is only honoured once the outstanding access completes.
        if (mem_ack_i) begin
          idRules   = 1'b1;
          waitCnt_d = '0;
          state_d   = start_i ? RUN : IDLE;
        end else begin
          freezeOut = 1'b1;
          if (waitCnt_q == WAIT_LAST) begin
            state_d   = HALT;
            timeout_d = 1'b1;
          end else begin
            waitCnt_d = waitCnt_q + WAIT_ONE;
          end
        end
      end
      HALT: begin
        freezeOut = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load-use beats any redirect: the branch/jump is re-evaluated next cycle.
  always_comb begin
    pc_stall_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    pc_sel_o       = 2'b00;

    if (idleOut) begin
      pc_stall_o   = 1'b1;
      ifid_stall_o = 1'b1;
    end else if (freezeOut) begin
      pc_stall_o     = 1'b1;
      ifid_stall_o   = 1'b1;
      exmem_stall_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (idRules) begin
      if (loadUse) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (jump_i) begin
        pc_sel_o     = 2'b10;
        ifid_flush_o = 1'b1;
      end else if (branch_taken_i) begin
        pc_sel_o     = 2'b01;
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((state_q == RUN || state_q == MEM_WAIT) && pc_stall_o &&
        (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      stallCnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      stallCnt_q <= stallCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, compared every cycle against a rule-level model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 64;
  localparam int STALL_MAX   = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble,
  //                       exmem_stall, memwb_bubble, pc_sel[1:0]}
  localparam logic [7:0] V_IDLE   = 8'b1100_0000;
  localparam logic [7:0] V_FREEZE = 8'b1100_1100;
  localparam logic [7:0] V_LU     = 8'b1101_0000;
  localparam logic [7:0] V_JUMP   = 8'b0010_0010;
  localparam logic [7:0] V_BR     = 8'b0010_0001;
  localparam logic [7:0] V_NONE   = 8'b0000_0000;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              idex_memread_i = 1'b0;
  logic [REG_AW-1:0] idex_rd_i = '0;
  logic [REG_AW-1:0] ifid_rs_i = '0;
  logic [REG_AW-1:0] ifid_rt_i = '0;
  logic              ifid_uses_rt_i = 1'b0;
  logic              branch_taken_i = 1'b0;
  logic              jump_i = 1'b0;
  logic              mem_req_i = 1'b0;
  logic              mem_ack_i = 1'b0;
  logic              pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o;
  logic              exmem_stall_o, memwb_bubble_o;
  logic [1:0]        pc_sel_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              timeout_o;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .ifid_uses_rt_i(ifid_uses_rt_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .exmem_stall_o(exmem_stall_o), .memwb_bubble_o(memwb_bubble_o),
    .pc_sel_o(pc_sel_o), .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode, frozen cycles of the current access, stall count.
  int mMode = M_IDLE;
  int mFrozen = 0;
  int mStalls = 0;
  bit mTimeout = 1'b0;

  function automatic logic [7:0] idRule(bit lu, bit jmp, bit br);
    if (lu) return V_LU;
    if (jmp) return V_JUMP;
    if (br) return V_BR;
    return V_NONE;
  endfunction

  function automatic logic [7:0] expOut(int mode, bit start, bit lu, bit jmp,
                                        bit br, bit req, bit ack);
    case (mode)
      M_IDLE: return V_IDLE;
      M_HALT: return V_FREEZE;
      M_RUN: begin
        if (!start) return V_IDLE;
        if (req && !ack) return V_FREEZE;
        return idRule(lu, jmp, br);
      end
      default: return ack ? idRule(lu, jmp, br) : V_FREEZE;
    endcase
  endfunction

  wire mLoadUse = idex_memread_i && (idex_rd_i != 0) &&
                  ((idex_rd_i == ifid_rs_i) ||
                   (ifid_uses_rt_i && (idex_rd_i == ifid_rt_i)));
  wire [7:0] expVec = expOut(mMode, start_i, mLoadUse, jump_i, branch_taken_i,
                             mem_req_i, mem_ack_i);
  wire [7:0] dutVec = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
                       exmem_stall_o, memwb_bubble_o, pc_sel_o};

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mMode    <= M_IDLE;
      mFrozen  <= 0;
      mStalls  <= 0;
      mTimeout <= 1'b0;
    end else begin
      if ((mMode == M_RUN || mMode == M_WAIT) && expVec[7] && mStalls < STALL_MAX)
        mStalls <= mStalls + 1;
      case (mMode)
        M_IDLE: if (start_i) mMode <= M_RUN;
        M_RUN: begin
          if (!start_i) mMode <= M_IDLE;
          else if (mem_req_i && !mem_ack_i) begin
            mMode   <= M_WAIT;
            mFrozen <= 1;
          end
        end
        M_WAIT: begin
          if (mem_ack_i) mMode <= start_i ? M_RUN : M_IDLE;
          else if (mFrozen + 1 == MEM_TIMEOUT) begin
            mMode    <= M_HALT;
            mTimeout <= 1'b1;
          end else mFrozen <= mFrozen + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput();
    compared++;
    if (dutVec !== expVec) begin
      mismatched++;
      $display("[TB] FAIL ctrl t=%0t dut=%b expected=%b", $time, dutVec, expVec);
    end
    compared++;
    if (int'(stall_cnt_o) != mStalls) begin
      mismatched++;
      $display("[TB] FAIL stall_cnt t=%0t dut=%0d expected=%0d", $time, stall_cnt_o, mStalls);
    end
    compared++;
    if (timeout_o !== mTimeout) begin
      mismatched++;
      $display("[TB] FAIL timeout t=%0t dut=%b expected=%b", $time, timeout_o, mTimeout);
    end
  endtask

  task automatic checkVal(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s t=%0t dut=%0h expected=%0h", name, $time, actual, expected);
    end
  endtask

  // Compare process: outputs settle 2 time units after the negedge drive.
  always begin
    @(negedge clk_i);
    #3;
    if (checkEn) checkOutput();
  end

  task automatic applyStimulus(bit start, bit memread, int rd, int rs, int rt,
                               bit usesRt, bit br, bit jmp, bit req, bit ack);
    @(negedge clk_i);
    #1;
    start_i        = start;
    idex_memread_i = memread;
    idex_rd_i      = REG_AW'(rd);
    ifid_rs_i      = REG_AW'(rs);
    ifid_rt_i      = REG_AW'(rt);
    ifid_uses_rt_i = usesRt;
    branch_taken_i = br;
    jump_i         = jmp;
    mem_req_i      = req;
    mem_ack_i      = ack;
  endtask

  task automatic resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic runStart();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checkEn = 1'b1;
    // Reset, idle for two cycles, then start.
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("idle_vec", 32'(dutVec), 32'(V_IDLE));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("idle_start_vec", 32'(dutVec), 32'(V_IDLE));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("run_vec", 32'(dutVec), 32'(V_NONE));
    checkVal("run_cnt", 32'(stall_cnt_o), 0);

    // Load-use beats branch; rd=0 never interlocks; jump beats branch.
    applyStimulus(1, 1, 5, 5, 0, 0, 1, 0, 0, 0);
    #2 checkVal("lu_vec", 32'(dutVec), 32'(V_LU));
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #2 checkVal("lu_rd0_vec", 32'(dutVec), 32'(V_BR));
    checkVal("lu_cnt", 32'(stall_cnt_o), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    #2 checkVal("jump_vec", 32'(dutVec), 32'(V_JUMP));
    applyStimulus(1, 1, 7, 1, 7, 1, 0, 0, 0, 0);
    #2 checkVal("lu_rt_vec", 32'(dutVec), 32'(V_LU));

    // Memory wait: ack arrives on the fourth request cycle.
    resetDut();
    runStart();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 checkVal("memwait_vec", 32'(dutVec), 32'(V_FREEZE));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 checkVal("memack_vec", 32'(dutVec), 32'(V_NONE));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("after_ack_vec", 32'(dutVec), 32'(V_NONE));
    checkVal("memwait_cnt", 32'(stall_cnt_o), 3);

    // Memory timeout after MEM_TIMEOUT frozen cycles; late ack ignored.
    resetDut();
    runStart();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #2 checkVal("pre_timeout", 32'(timeout_o), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2 checkVal("timeout_set", 32'(timeout_o), 1);
    checkVal("halt_vec", 32'(dutVec), 32'(V_FREEZE));
    checkVal("timeout_cnt_sat", 32'(stall_cnt_o), STALL_MAX);
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("timeout_clr", 32'(timeout_o), 0);
    checkVal("reset_idle_vec", 32'(dutVec), 32'(V_IDLE));

    // Long load-use stall saturates the counter.
    runStart();
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkVal("sat_cnt", 32'(stall_cnt_o), STALL_MAX);

    // Random traffic with small register indices so hazards are frequent.
    resetDut();
    for (int i = 0; i < 1500; i++) begin
      bit req;
      req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        resetDut();
      end else begin
        applyStimulus(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 1),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                      req, req ? ($urandom_range(0, 2) != 0) : $urandom_range(0, 1));
      end
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4 checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/next-PC controller for the 5-stage pipeline. It drives the PC register's stall and select inputs and the IF/ID, ID/EX, EX/MEM and MEM/WB hold/flush/bubble controls. It handles four conditions:
- load-use hazards;
- ID-stage branch and jump redirects;
- multi-cycle data-memory waits, with a timeout;
- run/idle sequencing from start_i.

It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, stall counter width
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before error (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
start_i  in  1  run enable; low = pipeline idle
idex_memread_i  in  1  instruction in EX is a load
idex_rd_i  in  REG_AW  EX destination register
ifid_rs_i  in  REG_AW  ID source rs
ifid_rt_i  in  REG_AW  ID source rt
ifid_uses_rt_i  in  1  ID instruction reads rt
branch_taken_i  in  1  ID branch resolved taken
jump_i  in  1  ID instruction is a jump
mem_req_i  in  1  MEM stage has a load/store
mem_ack_i  in  1  data memory completes access this cycle
pc_stall_o  out  1  hold PC
ifid_stall_o  out  1  hold IF/ID
ifid_flush_o  out  1  zero IF/ID
idex_bubble_o  out  1  insert NOP into ID/EX
exmem_stall_o  out  1  hold ID/EX and EX/MEM
memwb_bubble_o  out  1  insert NOP into MEM/WB
pc_sel_o  out  2  00 PC+4, 01 branch target, 10 jump target
stall_cnt_o  out  CNT_W  saturating count of stalled RUN/MEM_WAIT cycles
timeout_o  out  1  sticky memory timeout error

Behaviour:
- Reset is rst_i, asynchronous, active-low; clock is clk_i.
  - On reset: state=IDLE, wait counter=0, stall_cnt_o=0, timeout_o=0.
- Outputs are combinational from state and inputs (Mealy). Registered elements are: state, wait counter, stall_cnt_o, timeout_o.
- load_use = idex_memread_i & (idex_rd_i != 0) & ((idex_rd_i == ifid_rs_i) | (ifid_uses_rt_i & idex_rd_i == ifid_rt_i)).
- "Freeze" means: pc_stall_o = ifid_stall_o = exmem_stall_o = memwb_bubble_o = 1, all other outputs 0, pc_sel_o = 00.
- Default, when no rule below applies: all controls 0, pc_sel_o = 00.
- IDLE:
  - Outputs: pc_stall_o = ifid_stall_o = 1, everything else 0.
  - Transition: start_i=1 -> RUN next edge.
- RUN, rules applied in priority order:
  1. start_i=0: same outputs as IDLE; next state IDLE.
  2. mem_req_i & ~mem_ack_i: freeze; next state MEM_WAIT; wait counter <= 1.
  3. load_use: pc_stall_o = ifid_stall_o = idex_bubble_o = 1. Branch and jump are ignored this cycle (pc_sel_o = 00, no flush).
  4. jump_i: pc_sel_o = 10, ifid_flush_o = 1. Jump wins if branch_taken_i is also high.
  5. branch_taken_i: pc_sel_o = 01, ifid_flush_o = 1.
  - mem_req_i & mem_ack_i in the same cycle causes no stall.
- MEM_WAIT:
  - mem_ack_i=1: no freeze this cycle; rules 3-5 apply to the ID-stage inputs; next state RUN, or IDLE if start_i=0. start_i is ignored until ack.
  - mem_ack_i=0: freeze; wait counter increments.
  - If the counter equals MEM_TIMEOUT-1 and there is no ack: next state HALT, timeout_o <= 1.
- HALT:
  - Freeze permanently; timeout_o stays 1.
  - Exit only via reset; mem_ack_i and start_i are ignored.
- stall_cnt_o:
  - Increments on every edge where state is RUN or MEM_WAIT and pc_stall_o=1.
  - Saturates at 2^CNT_W-1.
  - Not counted in IDLE or HALT.
- Reset asserted mid-MEM_WAIT returns to IDLE immediately; pending accesses are abandoned.

Test Plan:
- Reset then start_i=1 at cycle 2 -> IDLE outputs (pc_stall_o=1, ifid_stall_o=1) through cycle 2; RUN from cycle 3 with all controls 0 and stall_cnt_o=0.
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs_i=5, branch_taken_i=1 -> pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1, pc_sel_o=00, ifid_flush_o=0; stall_cnt_o +1. Same case with idex_rd_i=0 -> no stall, pc_sel_o=01, ifid_flush_o=1.
- Jump and branch together in RUN -> pc_sel_o=10, ifid_flush_o=1, no stall.
- mem_req_i=1 with mem_ack_i delayed 3 cycles -> freeze for 3 cycles; release on the ack cycle; state RUN afterwards; stall_cnt_o=3.
- mem_req_i=1 with no ack, MEM_TIMEOUT=64 -> timeout_o=1 after 64 frozen cycles; state HALT; a late mem_ack_i has no effect; rst_i low clears to IDLE with timeout_o=0.
- CNT_W=4 with a long load-use stall -> stall_cnt_o saturates at 15 and does not wrap.
